keccak_round_engine: RTL and testbench



---
 rtl/keccak_pkg.sv | 53 +++++
 rtl/keccak_rc_rom.sv | 11 +
 rtl/permutation.sv | 57 +++++
 rtl/keccak_round_engine.sv | 86 ++++++++
 tb/tb_keccak_round_engine.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] definitions: sizes, FSM encoding, compressed round
// constants and the lane rotate helper used by the round logic.
package keccak_pkg;

  localparam int KECCAK_ROUNDS = 24;
  localparam int LANE_W        = 64;
  localparam int STATE_W       = 1600;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Bit k of RC7 lands on lane(0,0) bit 2^k-1 during iota
  function automatic logic [6:0] rc7(input logic [4:0] idx);
    logic [6:0] rc;
    case (idx)
      5'd0:  rc = 7'h01;
      5'd1:  rc = 7'h1A;
      5'd2:  rc = 7'h5E;
      5'd3:  rc = 7'h70;
      5'd4:  rc = 7'h1F;
      5'd5:  rc = 7'h21;
      5'd6:  rc = 7'h79;
      5'd7:  rc = 7'h55;
      5'd8:  rc = 7'h0E;
      5'd9:  rc = 7'h0C;
      5'd10: rc = 7'h35;
      5'd11: rc = 7'h26;
      5'd12: rc = 7'h3F;
      5'd13: rc = 7'h4F;
      5'd14: rc = 7'h5D;
      5'd15: rc = 7'h53;
      5'd16: rc = 7'h52;
      5'd17: rc = 7'h48;
      5'd18: rc = 7'h16;
      5'd19: rc = 7'h66;
      5'd20: rc = 7'h79;
      5'd21: rc = 7'h58;
      5'd22: rc = 7'h21;
      5'd23: rc = 7'h74;
      default: rc = 7'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] v,
                                               input int unsigned n);
    return (n == 0) ? v : ((v << n) | (v >> (LANE_W - n)));
  endfunction

endpackage

// File: rtl/keccak_rc_rom.sv
// Round index to compressed 7-bit round constant; one copy per unrolled stage.
module keccak_rc_rom
  import keccak_pkg::*;
(
  input  logic [4:0] round_idx,
  output logic [6:0] rc
);

  assign rc = rc7(round_idx);

endmodule

// File: rtl/permutation.sv
// One combinational Keccak-f[1600] round: theta, rho, pi, chi, iota.
module permutation
  import keccak_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [6:0]         round_const,
  output logic [STATE_W-1:0] result
);

  // Rotation amount for lane index 5y+x
  function automatic int unsigned rho_offset(input int idx);
    case (idx)
      0: return 0;   1: return 1;   2: return 62;  3: return 28;  4: return 27;
      5: return 36;  6: return 44;  7: return 6;   8: return 55;  9: return 20;
      10: return 3;  11: return 10; 12: return 43; 13: return 25; 14: return 39;
      15: return 41; 16: return 45; 17: return 15; 18: return 21; 19: return 8;
      20: return 18; 21: return 2;  22: return 61; 23: return 56; 24: return 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [LANE_W-1:0] expand_rc(input logic [6:0] rc);
    logic [LANE_W-1:0] v;
    v = '0;
    for (int k = 0; k < 7; k++) v[(1 << k) - 1] = rc[k];
    return v;
  endfunction

  logic [LANE_W-1:0] a [25];
  logic [LANE_W-1:0] b [25];
  logic [LANE_W-1:0] e [25];
  logic [LANE_W-1:0] c [5];
  logic [LANE_W-1:0] d [5];

  always_comb begin
    result = '0;
    for (int i = 0; i < 25; i++) begin
      a[i] = state[STATE_W-1-LANE_W*i -: LANE_W];
      b[i] = '0;
    end
    for (int x = 0; x < 5; x++)
      c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    for (int x = 0; x < 5; x++)
      d[x] = c[(x+4)%5] ^ rotl64(c[(x+1)%5], 1);
    // theta folded into rho/pi: lane (x,y) moves to (y, 2x+3y)
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        b[5*((2*x+3*y)%5)+y] = rotl64(a[5*y+x] ^ d[x], rho_offset(5*y+x));
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        e[5*y+x] = b[5*y+x] ^ (~b[5*y+(x+1)%5] & b[5*y+(x+2)%5]);
    e[0] = e[0] ^ expand_rc(round_const);
    for (int i = 0; i < 25; i++)
      result[STATE_W-1-LANE_W*i -: LANE_W] = e[i];
  end

endmodule

// File: rtl/keccak_round_engine.sv
// Iterative Keccak-f[1600] engine: UNROLL chained rounds per clock over a
// valid/ready in/out handshake.
module keccak_round_engine
  import keccak_pkg::*;
#(
  parameter int UNROLL = 1
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
        UNROLL == 6 || UNROLL == 8 || UNROLL == 12 || UNROLL == 24)) begin : g_bad_unroll
    $error("keccak_round_engine: UNROLL=%0d does not divide 24 rounds", UNROLL);
  end

  fsm_state_t         state, state_next;
  logic [4:0]         rnd_q;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] stage [UNROLL+1];
  logic [6:0]         rc [UNROLL];
  logic               last_step;
  logic               accept;

  assign stage[0] = state_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    logic [4:0] idx;
    assign idx = rnd_q + 5'(i);
    keccak_rc_rom u_rc (
      .round_idx (idx),
      .rc        (rc[i])
    );
    permutation u_round (
      .state       (stage[i]),
      .round_const (rc[i]),
      .result      (stage[i+1])
    );
  end

  assign last_step = (rnd_q + 5'(UNROLL)) == 5'(KECCAK_ROUNDS);
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = state_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      // A result held under back-pressure ignores new input until taken
      DONE: if (out_ready) state_next = in_valid ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // rnd_q parks at 24-UNROLL on the final step so it never reaches 24
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rnd_q   <= '0;
      state_q <= '0;
    end else if (accept) begin
      rnd_q   <= '0;
      state_q <= in_data;
    end else if (state == RUN) begin
      state_q <= stage[UNROLL];
      if (!last_step) rnd_q <= rnd_q + 5'(UNROLL);
    end
  end

endmodule

// File: tb/tb_keccak_round_engine.sv
// Bench for keccak_round_engine at UNROLL 1, 4 and 24 against a software
// Keccak-f[1600] whose constants are regenerated from the LFSR and rho walk.
module tb_keccak_round_engine;

  logic         clk;
  logic         reset;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [1599:0] in_data  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [1599:0] out_data [3];
  logic         busy      [3];

  int total = 0;
  int bad   = 0;

  keccak_round_engine #(.UNROLL(1)) u_dut_u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0])
  );

  keccak_round_engine #(.UNROLL(4)) u_dut_u4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1])
  );

  keccak_round_engine #(.UNROLL(24)) u_dut_u24 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 24 : (d == 1) ? 6 : 1;
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    int m;
    m = n % 64;
    if (m == 0) return v;
    return (v << m) | (v >> (64 - m));
  endfunction

  // Reference Keccak-f[1600]; lane(x,y) at bits [1599-64*(5y+x) -: 64]
  function automatic logic [1599:0] keccak_f(input logic [1599:0] s_in);
    logic [63:0] a [5][5];
    logic [63:0] b [5][5];
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] rcs [24];
    int          r [5][5];
    logic [7:0]  lfsr;
    int          x, y, tmp;
    logic [1599:0] s_out;

    lfsr = 8'h01;
    for (int i = 0; i < 24; i++) begin
      rcs[i] = '0;
      for (int j = 0; j < 7; j++) begin
        if (lfsr[0]) rcs[i] = rcs[i] ^ (64'd1 << ((1 << j) - 1));
        lfsr = lfsr[7] ? ((lfsr << 1) ^ 8'h71) : (lfsr << 1);
      end
    end

    r[0][0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      r[x][y] = ((t + 1) * (t + 2) / 2) % 64;
      tmp = y;
      y = (2 * x + 3 * y) % 5;
      x = tmp;
    end

    for (int i = 0; i < 25; i++) a[i % 5][i / 5] = s_in[1599 - 64*i -: 64];

    for (int rnd = 0; rnd < 24; rnd++) begin
      for (int xi = 0; xi < 5; xi++)
        c[xi] = a[xi][0] ^ a[xi][1] ^ a[xi][2] ^ a[xi][3] ^ a[xi][4];
      for (int xi = 0; xi < 5; xi++)
        d[xi] = c[(xi + 4) % 5] ^ rot(c[(xi + 1) % 5], 1);
      for (int xi = 0; xi < 5; xi++)
        for (int yi = 0; yi < 5; yi++)
          a[xi][yi] = a[xi][yi] ^ d[xi];
      for (int xi = 0; xi < 5; xi++)
        for (int yi = 0; yi < 5; yi++)
          b[yi][(2*xi + 3*yi) % 5] = rot(a[xi][yi], r[xi][yi]);
      for (int xi = 0; xi < 5; xi++)
        for (int yi = 0; yi < 5; yi++)
          a[xi][yi] = b[xi][yi] ^ (~b[(xi + 1) % 5][yi] & b[(xi + 2) % 5][yi]);
      a[0][0] = a[0][0] ^ rcs[rnd];
    end

    s_out = '0;
    for (int i = 0; i < 25; i++) s_out[1599 - 64*i -: 64] = a[i % 5][i / 5];
    return s_out;
  endfunction

  function automatic logic [1599:0] rand_state();
    logic [1599:0] v;
    v = '0;
    for (int i = 0; i < 50; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [1599:0] observed,
                             input logic [1599:0] expected);
    int lane;
    lane = -1;
    for (int i = 0; i < 25; i++)
      if (lane < 0 && observed[1599 - 64*i -: 64] !== expected[1599 - 64*i -: 64])
        lane = i;
    if (lane < 0) lane = 0;
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s lane=%0d observed=%h expected=%h", tag, lane,
             observed[1599 - 64*lane -: 64], expected[1599 - 64*lane -: 64]);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic apply_stimulus(input int d, input logic [1599:0] data, input string tag);
    int n;
    n = 0;
    in_data[d]  = data;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output({tag, "_accept_ready"}, 64'(in_ready[d]), 64'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  // Waits for out_valid after an accept, checking latency, busy time and data
  task automatic wait_result(input int d, input logic [1599:0] expected, input string tag);
    int n;
    int busy_n;
    n = 0;
    busy_n = busy[d] ? 1 : 0;
    while (!out_valid[d] && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy[d]) busy_n++;
    end
    check_output({tag, "_latency"}, 64'(n), 64'(lat_of(d)));
    check_output({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat_of(d)));
    check_state({tag, "_data"}, out_data[d], expected);
  endtask

  task automatic back_pressure(input int d);
    logic [1599:0] job_a, job_b, exp_a, exp_b;
    int rdy_hi, vld_lo, data_chg;
    job_a = rand_state();
    job_b = rand_state();
    exp_a = keccak_f(job_a);
    exp_b = keccak_f(job_b);
    out_ready[d] = 1'b0;
    apply_stimulus(d, job_a, "bp_first");
    wait_result(d, exp_a, "bp_first");
    in_data[d]  = job_b;
    in_valid[d] = 1'b1;
    rdy_hi = 0; vld_lo = 0; data_chg = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready[d]) rdy_hi++;
      if (!out_valid[d]) vld_lo++;
      if (out_data[d] !== exp_a) data_chg++;
      @(posedge clk); #1;
    end
    check_output("bp_in_ready_high", 64'(rdy_hi), 64'd0);
    check_output("bp_out_valid_low", 64'(vld_lo), 64'd0);
    check_output("bp_data_changed", 64'(data_chg), 64'd0);
    out_ready[d] = 1'b1;
    #1;
    check_output("bp_release_ready", 64'(in_ready[d]), 64'd1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    check_output("bp_second_running", 64'(out_valid[d]), 64'd0);
    wait_result(d, exp_b, "bp_second");
  endtask

  task automatic back_to_back(input int d);
    logic [1599:0] jobs [3];
    logic [1599:0] exps [3];
    int acc_t [3];
    int na, no, n;
    logic will_acc;
    for (int i = 0; i < 3; i++) begin
      jobs[i]  = rand_state();
      exps[i]  = keccak_f(jobs[i]);
      acc_t[i] = 0;
    end
    na = 0; no = 0; n = 0;
    out_ready[d] = 1'b1;
    in_data[d]   = jobs[0];
    in_valid[d]  = 1'b1;
    while ((na < 3 || no < 3) && n < 300) begin
      will_acc = in_valid[d] && in_ready[d];
      if (out_valid[d]) begin
        if (no < 3) check_state("b2b_out", out_data[d], exps[no]);
        else        check_output("b2b_extra_out", 64'd1, 64'd0);
        no++;
      end
      @(posedge clk); #1;
      n++;
      if (will_acc) begin
        acc_t[na] = n;
        na++;
        if (na < 3) in_data[d] = jobs[na];
        else        in_valid[d] = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    check_output("b2b_accepts", 64'(na), 64'd3);
    check_output("b2b_outputs", 64'(no), 64'd3);
    check_output("b2b_spacing01", 64'(acc_t[1] - acc_t[0]), 64'(lat_of(d) + 1));
    check_output("b2b_spacing12", 64'(acc_t[2] - acc_t[1]), 64'(lat_of(d) + 1));
  endtask

  initial begin
    logic [1599:0] zero_exp;
    logic [1599:0] job;
    int seen;

    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    zero_exp = keccak_f('0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_output("rst_in_ready", 64'(in_ready[d]), 64'd1);
      check_output("rst_out_valid", 64'(out_valid[d]), 64'd0);
      check_output("rst_busy", 64'(busy[d]), 64'd0);
      check_state("rst_out_data", out_data[d], '0);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      $display("[TB] UNROLL instance %0d: latency %0d", d, lat_of(d));
      apply_stimulus(d, '0, "zero");
      wait_result(d, zero_exp, "zero");
      check_output("zero_lane00", out_data[d][1599:1536], 64'hF1258F7940E1DDE7);
      check_output("zero_lane10", out_data[d][1535:1472], 64'h84D5CCF933C0478A);
      @(posedge clk); #1;
      back_pressure(d);
      @(posedge clk); #1;
      back_to_back(d);
      repeat (3) @(posedge clk);
      #1;
    end

    // Abort a UNROLL=1 job during round 11
    apply_stimulus(0, rand_state(), "abort");
    repeat (11) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check_output("async_rst_in_ready", 64'(in_ready[d]), 64'd1);
      check_output("async_rst_busy", 64'(busy[d]), 64'd0);
      check_output("async_rst_out_valid", 64'(out_valid[d]), 64'd0);
    end
    @(posedge clk);
    #3 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen++;
    end
    check_output("abort_no_out_valid", 64'(seen), 64'd0);
    job = rand_state();
    apply_stimulus(0, job, "after_rst");
    wait_result(0, keccak_f(job), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
